// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared state type and default constants for the Booth result checker
package booth_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT,
      CMP,
      FIN_HI,
      FIN_LO,
      GUARD,
      DONE
   } chk_state_t;

   localparam int          BOOTH_DEF_WIDTH        = 32;
   localparam logic [31:0] BOOTH_DEF_MULTIPLICAND = 32'h5555_5555;
   localparam int          BOOTH_FRAME_PERIOD     = 12;
   localparam int          FIN_HOLD               = 3;

endpackage

// File: rtl/booth_result_checker_if.sv
// rtl/booth_result_checker_if.sv - harness/checker signal bundle
// First-mismatch capture signals exist only when BOOTH_CHK_ERRCAP_EN is defined.
interface booth_result_checker_if #(
   parameter int WIDTH = 32
);
   logic                 start;
   logic [2*WIDTH-1:0]   result;
   logic                 finish;
   logic                 busy;
   logic                 done;
   logic                 pass;
   logic [15:0]          err_count;
   logic [WIDTH-1:0]     vec_idx;
`ifdef BOOTH_CHK_ERRCAP_EN
   logic                 err_valid;
   logic [WIDTH-1:0]     err_operand;
   logic [2*WIDTH-1:0]   err_obs;

   modport master (
      output start, result,
      input  finish, busy, done, pass, err_count, vec_idx,
      input  err_valid, err_operand, err_obs
   );
   modport slave (
      input  start, result,
      output finish, busy, done, pass, err_count, vec_idx,
      output err_valid, err_operand, err_obs
   );
`else
   modport master (
      output start, result,
      input  finish, busy, done, pass, err_count, vec_idx
   );
   modport slave (
      input  start, result,
      output finish, busy, done, pass, err_count, vec_idx
   );
`endif
endinterface

// File: rtl/booth_finish_gen.sv
// rtl/booth_finish_gen.sv - finish pulse shaper: FIN_HOLD cycles high, FIN_HOLD cycles low
// The low phase lets the harness re-arm its synchronised rising-edge detect.
module booth_finish_gen
   import booth_pkg::*;
(
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_go,
   output logic o_finish,
   output logic o_idle
);
   localparam int             CW        = $clog2(FIN_HOLD + 1);
   localparam logic [CW-1:0]  HOLD_LAST = CW'(FIN_HOLD - 1);

   typedef enum logic [1:0] {PH_IDLE, PH_HI, PH_LO} fin_phase_t;

   fin_phase_t    r_phase;
   logic [CW-1:0] r_cnt;
   logic          r_finish;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_phase  <= PH_IDLE;
         r_cnt    <= '0;
         r_finish <= 1'b0;
      end else if (i_go) begin
         r_phase  <= PH_HI;
         r_cnt    <= '0;
         r_finish <= 1'b1;
      end else begin
         case (r_phase)
            PH_HI: begin
               if (r_cnt == HOLD_LAST) begin
                  r_phase  <= PH_LO;
                  r_cnt    <= '0;
                  r_finish <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            PH_LO: begin
               if (r_cnt == HOLD_LAST) r_phase <= PH_IDLE;
               else                    r_cnt   <= r_cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign o_finish = r_finish;
   assign o_idle   = (r_phase == PH_IDLE);

endmodule

// File: rtl/booth_result_checker.sv
// rtl/booth_result_checker.sv - golden-product checker closing the Booth harness finish loop
// Optional first-mismatch capture (err_valid/err_operand/err_obs) under BOOTH_CHK_ERRCAP_EN.
module booth_result_checker
   import booth_pkg::*;
#(
   parameter int               WIDTH        = BOOTH_DEF_WIDTH,
   parameter logic [WIDTH-1:0] MULTIPLICAND = WIDTH'(BOOTH_DEF_MULTIPLICAND),
   parameter int               PERIOD       = BOOTH_FRAME_PERIOD,
   parameter int               NUM_VECTORS  = 256
) (
   input logic                   i_clk,
   input logic                   i_rst,
   booth_result_checker_if.slave bus
);
   localparam int               PW       = 2 * WIDTH;
   localparam int               CW       = $clog2(PERIOD + 1);
   localparam logic [CW-1:0]    PER_LAST = CW'(PERIOD - 1);
   localparam logic [WIDTH-1:0] E_LAST   = WIDTH'(NUM_VECTORS - 1);

   chk_state_t       r_state;
   chk_state_t       w_next;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_vec;
   logic [PW-1:0]    r_obs;
   logic [PW-1:0]    w_exp;
   logic [15:0]      r_err;
   logic [15:0]      w_err_next;
   logic             r_busy;
   logic             r_done;
   logic             r_pass;
   logic             w_go;
   logic             w_fin;
   logic             w_fin_idle;
   logic             w_seen;
   logic             w_timeout;
   logic             w_mismatch;
   logic             w_last;

   assign w_exp      = PW'(MULTIPLICAND) * PW'(r_vec);
   assign w_seen     = (bus.result != '0);
   assign w_timeout  = (r_cnt == PER_LAST);
   assign w_mismatch = (r_obs != w_exp);
   assign w_last     = (r_vec == E_LAST);

   booth_finish_gen u_fin (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_go     (w_go),
      .o_finish (w_fin),
      .o_idle   (w_fin_idle)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      w_go       = 1'b0;
      w_err_next = r_err;
      case (r_state)
         IDLE, DONE: begin
            if (bus.start) begin
               w_next     = WAIT;
               w_err_next = '0;
            end
         end
         WAIT:   if (w_seen || w_timeout) w_next = CMP;
         CMP: begin
            if (w_mismatch && (r_err != 16'hFFFF)) w_err_next = r_err + 16'd1;
            if (w_last) begin
               w_next = DONE;
            end else begin
               w_next = FIN_HI;
               w_go   = 1'b1;
            end
         end
         FIN_HI: if (!w_fin)     w_next = FIN_LO;
         FIN_LO: if (w_fin_idle) w_next = GUARD;
         GUARD:  if (w_timeout)  w_next = WAIT;
         default: w_next = IDLE;
      endcase
   end

   // Status flags follow the next state so they are registered yet line up with it.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt  <= '0;
         r_vec  <= '0;
         r_obs  <= '0;
         r_err  <= '0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
         r_pass <= 1'b0;
      end else begin
         r_err  <= w_err_next;
         r_busy <= (w_next != IDLE) && (w_next != DONE);
         r_done <= (w_next == DONE);
         r_pass <= (w_next == DONE) && (w_err_next == '0);
         case (r_state)
            IDLE, DONE: begin
               if (bus.start) begin
                  r_vec <= '0;
                  r_cnt <= '0;
                  r_obs <= '0;
               end
            end
            WAIT: begin
               if (w_seen) begin
                  r_obs <= bus.result;
                  r_cnt <= '0;
               end else if (w_timeout) begin
                  r_obs <= '0;
                  r_cnt <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            CMP: begin
               r_cnt <= '0;
               if (!w_last) r_vec <= r_vec + 1'b1;
            end
            GUARD:   r_cnt <= w_timeout ? '0 : r_cnt + 1'b1;
            default: ;
         endcase
      end
   end

   assign bus.finish    = w_fin;
   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.pass      = r_pass;
   assign bus.err_count = r_err;
   assign bus.vec_idx   = r_vec;

`ifdef BOOTH_CHK_ERRCAP_EN
   logic             r_err_valid;
   logic [WIDTH-1:0] r_err_operand;
   logic [PW-1:0]    r_err_obs;
   logic             w_start_ok;

   assign w_start_ok = bus.start && ((r_state == IDLE) || (r_state == DONE));

   always_ff @(posedge i_clk) begin
      if (i_rst || w_start_ok) begin
         r_err_valid   <= 1'b0;
         r_err_operand <= '0;
         r_err_obs     <= '0;
      end else if ((r_state == CMP) && w_mismatch && !r_err_valid) begin
         r_err_valid   <= 1'b1;
         r_err_operand <= r_vec;
         r_err_obs     <= r_obs;
      end
   end

   assign bus.err_valid   = r_err_valid;
   assign bus.err_operand = r_err_operand;
   assign bus.err_obs     = r_err_obs;
`endif

endmodule

// File: tb/tb_booth_result_checker.sv
// tb/tb_booth_result_checker.sv - scoreboard bench with a behavioural Booth harness model
module tb_booth_result_checker;
   import booth_pkg::*;

   localparam int          WIDTH  = 32;
   localparam int          PERIOD = 12;
   localparam int          NV     = 8;
   localparam logic [31:0] MULT   = 32'h5555_5555;

   logic clk   = 1'b0;
   logic rst   = 1'b1;
   logic h_rst = 1'b0;
   always #5 clk = ~clk;

   booth_result_checker_if #(.WIDTH(WIDTH)) bus ();

   booth_result_checker #(
      .WIDTH        (WIDTH),
      .MULTIPLICAND (MULT),
      .PERIOD       (PERIOD),
      .NUM_VECTORS  (NV)
   ) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   // Harness model: 2-flop sync + edge detect on finish advances the operand.
   int          op;
   int          fault_e = -1;
   int          miss_e  = -1;
   logic        s1, s2, s3;
   logic [63:0] res;

   always @(posedge clk) begin
      if (rst || h_rst) begin
         s1 <= 1'b0; s2 <= 1'b0; s3 <= 1'b0; op <= 0; res <= '0;
      end else begin
         s1 <= bus.finish; s2 <= s1; s3 <= s2;
         if (s2 && !s3) op <= op + 1;
         if (op == miss_e)       res <= '0;
         else if (op == fault_e) res <= (64'(MULT) * 64'(op)) ^ 64'd1;
         else                    res <= 64'(MULT) * 64'(op);
      end
   end
   assign bus.result = res;

   typedef struct {
      logic [15:0] err;
      logic        pass;
      logic [31:0] vec;
   } done_t;

   int    total = 0;
   int    bad   = 0;
   int    q_fin[$];
   done_t q_done[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Monitor: scores every finish pulse width and every done rising edge.
   initial begin
      int    width = 0;
      logic  prev_fin = 1'b0;
      logic  prev_done = 1'b0;
      done_t d;
      forever begin
         @(negedge clk);
         if (bus.finish) begin
            width++;
         end else if (prev_fin) begin
            if (q_fin.size() == 0) begin
               total++; bad++;
               $display("FAIL finish_unexpected: got pulse of %0d cycles want none", width);
            end else begin
               check("finish_width", width, q_fin.pop_front());
            end
            width = 0;
         end
         prev_fin = bus.finish;
         if (bus.done && !prev_done) begin
            if (q_done.size() == 0) begin
               total++; bad++;
               $display("FAIL done_unexpected: got done want none");
            end else begin
               d = q_done.pop_front();
               check("done_err_count", bus.err_count, d.err);
               check("done_pass", bus.pass, d.pass);
               check("done_vec_idx", bus.vec_idx, d.vec);
               check("done_busy", bus.busy, 1'b0);
            end
         end
         prev_done = bus.done;
      end
   end

   task automatic pulse_start();
      @(negedge clk) bus.start = 1'b1;
      @(negedge clk) bus.start = 1'b0;
   endtask

   task automatic harness_reset();
      @(negedge clk) h_rst = 1'b1;
      @(negedge clk) h_rst = 1'b0;
   endtask

   task automatic expect_run(input logic [15:0] err, input logic pass);
      done_t d;
      for (int i = 0; i < NV - 1; i++) q_fin.push_back(FIN_HOLD);
      d.err  = err;
      d.pass = pass;
      d.vec  = 32'(NV - 1);
      q_done.push_back(d);
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (!bus.done && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (!bus.done) begin
         total++; bad++;
         $display("FAIL %s_timeout: got no done after %0d cycles want done", name, n);
      end
      @(negedge clk);
      check({name, "_fin_left"}, q_fin.size(), 0);
      check({name, "_done_left"}, q_done.size(), 0);
   endtask

   initial begin
      int n;
      bus.start = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      repeat (10) @(negedge clk);
      check("rst_busy", bus.busy, 1'b0);
      check("rst_done", bus.done, 1'b0);
      check("rst_pass", bus.pass, 1'b0);
      check("rst_err_count", bus.err_count, 16'd0);
      check("rst_vec_idx", bus.vec_idx, 32'd0);
      check("rst_finish", bus.finish, 1'b0);

      // start coinciding with rst must be ignored
      @(negedge clk) begin rst = 1'b1; bus.start = 1'b1; end
      @(negedge clk) begin rst = 1'b0; bus.start = 1'b0; end
      repeat (3) @(negedge clk);
      check("start_with_rst_busy", bus.busy, 1'b0);

      // golden run with spurious starts while busy
      expect_run(16'd0, 1'b1);
      pulse_start();
      repeat (40) @(negedge clk);
      pulse_start();
      repeat (100) @(negedge clk);
      pulse_start();
      wait_done("golden");
      repeat (5) @(negedge clk);
      check("golden_done_hold", bus.done, 1'b1);
      check("golden_pass_hold", bus.pass, 1'b1);

      // fault injection at E=3, restarted straight from DONE
      harness_reset();
      fault_e = 3;
      expect_run(16'd1, 1'b0);
      pulse_start();
      wait_done("fault");
`ifdef BOOTH_CHK_ERRCAP_EN
      check("fault_err_valid", bus.err_valid, 1'b1);
      check("fault_err_operand", bus.err_operand, 32'd3);
      check("fault_err_obs", bus.err_obs, 64'h0000_0000_FFFF_FFFE);
`endif
      fault_e = -1;

      // missing product at E=2
      harness_reset();
      miss_e = 2;
      expect_run(16'd1, 1'b0);
      pulse_start();
      wait_done("missing");
`ifdef BOOTH_CHK_ERRCAP_EN
      check("missing_err_operand", bus.err_operand, 32'd2);
      check("missing_err_obs", bus.err_obs, 64'd0);
`endif
      miss_e = -1;

      // mid-run reset during GUARD of vector 4
      harness_reset();
      expect_run(16'd0, 1'b1);
      pulse_start();
      n = 0;
      while (bus.vec_idx != 32'd4 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("midrst_reached_vec4", bus.vec_idx, 32'd4);
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_busy", bus.busy, 1'b0);
      check("midrst_finish", bus.finish, 1'b0);
      check("midrst_err_count", bus.err_count, 16'd0);
      check("midrst_vec_idx", bus.vec_idx, 32'd0);
      check("midrst_done", bus.done, 1'b0);
      check("midrst_fin_consumed", q_fin.size(), NV - 1 - 4);
      rst = 1'b0;
      q_fin.delete();
      q_done.delete();
      repeat (3) @(negedge clk);

      expect_run(16'd0, 1'b1);
      pulse_start();
      wait_done("rerun");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/booth_result_checker.md
# booth_result_checker

Self-checking consumer at the far end of the radix-4 Booth test harness. Closes the `finish` handshake loop: samples the 2×WIDTH product, compares it against a golden `MULTIPLICAND × E` for expected operand E, then pulses `finish` so the harness advances its operand. Sits beside the harness in the same `clk` domain and replaces manual waveform inspection with pass/fail status.

## Interface
- `WIDTH`, 32: operand width; product is 2×WIDTH.
- `MULTIPLICAND`, 32'h55555555: fixed multiplicand the harness uses.
- `PERIOD`, 12: harness frame length in cycles; the harness drives one non-zero operand per frame.
- `NUM_VECTORS`, 256: operands checked (E = 0 … NUM_VECTORS-1); ≤ 2^WIDTH.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse; begins a run from IDLE or DONE.
- `result` in 2×WIDTH: product from the Booth multiplier.
- `finish` out 1: handshake to the harness, one high pulse per advance.
- `busy` out 1: high in every state except IDLE and DONE.
- `done` out 1: high in DONE.
- `pass` out 1: high in DONE when `err_count` is 0.
- `err_count` out 16: saturating mismatch count.
- `vec_idx` out WIDTH: current expected operand E.

## Operation
- FSM: IDLE → WAIT → CMP → (FIN_HI → FIN_LO → GUARD → WAIT) … → DONE.
- IDLE: all outputs 0. `start` clears E, `err_count`, `pass`, and `done`, then enters WAIT.
- WAIT: watches `result` for up to PERIOD cycles.
  - First non-zero `result` is captured as `obs` → CMP.
  - If PERIOD cycles pass with `result` at 0: `obs` = 0 → CMP.
- CMP (1 cycle): `exp` = MULTIPLICAND × E as an unsigned 2×WIDTH product.
  - If `obs` ≠ `exp`, `err_count` += 1, saturating at 16'hFFFF.
  - If E = NUM_VECTORS-1 → DONE. Otherwise E += 1 → FIN_HI.
- FIN_HI: `finish` = 1 for 3 cycles. This meets the harness's 2-flop synchroniser and rising-edge detect.
- FIN_LO: `finish` = 0 for 3 cycles, so the harness re-arms its edge detect.
- GUARD: PERIOD cycles with `result` ignored. This flushes any frame still carrying the old operand → WAIT.
- DONE: `done` = 1 and `pass` = (`err_count` = 0), both held. `start` → new run. Other inputs are ignored.
- `start` in any busy state is ignored.
- `rst` wins over `start` in the same cycle.
- `rst` mid-run: next edge → IDLE, with `finish`, `busy`, `done`, `pass`, `err_count`, and `vec_idx` all 0. The harness must be reset alongside.
- E = 0 produces `exp` = 0. A zero-result timeout therefore counts as a pass only for E = 0; for any other E it is a mismatch ("missing product").

## Timing
- All outputs are registered; reset values are listed in IDLE.
- First vector: `start` at edge t → WAIT from t+1. No `finish` is sent first, because the harness operand is 0 out of reset.
- Per-vector loop: 3 (FIN_HI) + 3 (FIN_LO) + PERIOD (GUARD) + ≤PERIOD (WAIT) + 1 (CMP). That is ≤ 31 cycles at defaults.
- `finish` rises on the edge after CMP and is high for exactly 3 consecutive cycles.
- `done` rises on the edge after the final CMP.
- `err_count` updates on the edge leaving CMP.

## Configuration
- `BOOTH_CHK_ERRCAP_EN` defined:
  - Adds outputs `err_valid` (1), `err_operand` (WIDTH), and `err_obs` (2×WIDTH).
  - These latch E and `obs` of the first mismatch in a run.
  - Cleared by `rst` and `start`; `err_valid` goes 1 at that CMP.
- Undefined: those ports and registers do not exist. All other behaviour is identical.

## Structure
- Package `booth_pkg`:
  - State enum `chk_state_t` (IDLE, WAIT, CMP, FIN_HI, FIN_LO, GUARD, DONE).
  - Constants `BOOTH_DEF_WIDTH` = 32, `BOOTH_DEF_MULTIPLICAND` = 32'h55555555, `BOOTH_FRAME_PERIOD` = 12, `FIN_HOLD` = 3.
- One sub-module, `booth_finish_gen`:
  - Input: a one-cycle `go`.
  - Output: `finish` high for FIN_HOLD cycles, then low for FIN_HOLD cycles, with `idle` flagging completion.
  - The FSM's FIN_HI and FIN_LO states wait on it.

## Test plan
- Reset then idle: `rst` held 5 cycles, no `start` → all outputs 0 and `finish` never rises.
- Golden run with the real harness and multiplier, NUM_VECTORS = 8 → 7 `finish` pulses of 3 cycles each, `done` = 1, `pass` = 1, `err_count` = 0, `vec_idx` = 7.
- Fault injection: a harness model returns `exp` XOR 1 for E = 3 only → `err_count` = 1 and `pass` = 0. With `BOOTH_CHK_ERRCAP_EN`: `err_operand` = 3 and `err_obs` = 64'h0000_0000_FFFF_FFFE.
- Missing product: the model holds `result` at 0 for E = 2 → WAIT times out after 12 cycles and `err_count` = 1.
- Mid-run reset: `rst` asserted during GUARD of vector 4 → next cycle `busy` = 0, `finish` = 0, `err_count` = 0. A later `start` reruns cleanly to `pass` = 1.
- `start` during busy and `start` coinciding with `rst` → both ignored; the run length and counts are unchanged.
